// File: rtl/test_engine_nic_output_control_unit_pkg.sv
// Shared definitions for the test engine NIC transmit control path:
// flit count, FSM state encodings and the credit counter width helper.
package test_engine_nic_output_control_unit_pkg;

  localparam int DATA_FLITS = 2;
  localparam int FLITS      = DATA_FLITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01
  } tx_state_e;

  // A counter that must hold values 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/test_engine_nic_output_control_unit_credit_counter.sv
// Saturating credit counter shared by the NIC transmit and receive sides.
// Starts full at BUFFER_DEPTH; simultaneous increment and decrement cancel.
module test_engine_nic_credit_counter
  import test_engine_nic_output_control_unit_pkg::*;
#(
  parameter  int BUFFER_DEPTH = 4,
  localparam int CW           = credit_width(BUFFER_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          increment,
  input  logic          decrement,
  output logic [CW-1:0] count,
  output logic          zero
);

  localparam logic [CW-1:0] MAX_CNT  = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  logic [CW-1:0] count_r;

  // Credit count register: credits above BUFFER_DEPTH are dropped, never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= MAX_CNT;
    end else if (increment && !decrement && (count_r != MAX_CNT)) begin
      count_r <= count_r + ONE_CNT;
    end else if (decrement && !increment && (count_r != ZERO_CNT)) begin
      count_r <= count_r - ONE_CNT;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == ZERO_CNT);

endmodule

// File: rtl/test_engine_nic_output_control_unit.sv
// NIC transmit control: sequences header + data flits under credit flow control.
// Optional TEST_ENGINE_NIC_TX_BACK2BACK_EN accepts a new result in the last-flit cycle.
module test_engine_nic_output_control_unit
  import test_engine_nic_output_control_unit_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done_strobe_din,
  input  logic             credit_in_din,
  output logic             load_strobe_dout,
  output logic             channel_valid_dout,
  output logic [FLITS-1:0] flit_select_dout,
  output logic             busy_engine_dout,
  output logic             zero_credits_dout
);

  localparam int               CW      = credit_width(BUFFER_DEPTH);
  localparam logic [FLITS-1:0] SEL_HDR = {{DATA_FLITS{1'b0}}, 1'b1};

  tx_state_e        state_r, state_nxt_s;
  logic [FLITS-1:0] sel_r, sel_nxt_s;
  logic [CW-1:0]    credit_count_s;
  logic             zero_s;
  logic             valid_s;
  logic             last_flit_s;
  logic             load_s;

  test_engine_nic_credit_counter #(
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .increment(credit_in_din),
    .decrement(valid_s),
    .count    (credit_count_s),
    .zero     (zero_s)
  );

  assign valid_s     = (state_r == SEND) && !zero_s;
  assign last_flit_s = valid_s && sel_r[DATA_FLITS];

  // State and flit-select registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sel_r   <= SEL_HDR;
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
    end
  end

  // Next-state, select advance and load strobe.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (done_strobe_din) begin
          state_nxt_s = SEND;
          load_s      = 1'b1;
          sel_nxt_s   = SEL_HDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (last_flit_s) begin
          sel_nxt_s = SEL_HDR;
`ifdef TEST_ENGINE_NIC_TX_BACK2BACK_EN
          if (done_strobe_din) begin
            state_nxt_s = SEND;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
`else
          state_nxt_s = IDLE;
`endif
        end else if (valid_s) begin
          sel_nxt_s = sel_r << 1;
        end else begin
          sel_nxt_s = sel_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        sel_nxt_s   = SEL_HDR;
      end
    endcase
  end

  assign load_strobe_dout   = load_s;
  assign channel_valid_dout = valid_s;
  assign flit_select_dout   = sel_r;
  assign zero_credits_dout  = zero_s;
`ifdef TEST_ENGINE_NIC_TX_BACK2BACK_EN
  assign busy_engine_dout   = (state_r != IDLE) && !last_flit_s;
`else
  assign busy_engine_dout   = (state_r != IDLE);
`endif

endmodule

// File: tb/tb_test_engine_nic_output_control_unit.sv
// Scoreboard bench for the NIC transmit control unit (DATA_FLITS=2, BUFFER_DEPTH=4).
// Expected flit selects are queued by the stimulus; a negedge monitor checks each valid flit.
module tb_test_engine_nic_output_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       done_strobe_din;
  logic       credit_in_din;
  logic       load_strobe_dout;
  logic       channel_valid_dout;
  logic [2:0] flit_select_dout;
  logic       busy_engine_dout;
  logic       zero_credits_dout;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  test_engine_nic_output_control_unit #(.BUFFER_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .done_strobe_din   (done_strobe_din),
    .credit_in_din     (credit_in_din),
    .load_strobe_dout  (load_strobe_dout),
    .channel_valid_dout(channel_valid_dout),
    .flit_select_dout  (flit_select_dout),
    .busy_engine_dout  (busy_engine_dout),
    .zero_credits_dout (zero_credits_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
  endtask

  // Monitor: every valid flit must match the next queued select.
  always @(negedge clk) begin
    if (channel_valid_dout) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit: got select %b with empty queue at %0t", flit_select_dout, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (flit_select_dout !== e) begin
          errors++;
          $display("FAIL flit_select: got %b expected %b at %0t", flit_select_dout, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    done_strobe_din = 1'b0;
    credit_in_din = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    // Reset/idle state
    chk("rst_sel", int'(flit_select_dout), 1);
    chk("rst_valid", int'(channel_valid_dout), 0);
    chk("rst_busy", int'(busy_engine_dout), 0);
    chk("rst_zero", int'(zero_credits_dout), 0);
    chk("rst_load", int'(load_strobe_dout), 0);
    chk("rst_count", int'(dut.credit_count_s), 4);

    // Packet 1: full credits, no gaps
    done_strobe_din = 1'b1;
    push_pkt();
    #1 chk("p1_load", int'(load_strobe_dout), 1);
    step(); done_strobe_din = 1'b0;
    chk("p1_valid_t1", int'(channel_valid_dout), 1);
    chk("p1_busy_t1", int'(busy_engine_dout), 1);
    #1 chk("p1_load_busy", int'(load_strobe_dout), 0);
    step();
    chk("p1_valid_t2", int'(channel_valid_dout), 1);
    step();
    chk("p1_valid_t3", int'(channel_valid_dout), 1);
    step();
    chk("p1_busy_t4", int'(busy_engine_dout), 0);
    chk("p1_valid_t4", int'(channel_valid_dout), 0);
    chk("p1_count", int'(dut.credit_count_s), 1);

    // Packet 2: one credit left, stall on second flit
    done_strobe_din = 1'b1;
    push_pkt();
    #1 chk("p2_load", int'(load_strobe_dout), 1);
    step(); done_strobe_din = 1'b0;
    chk("p2_hdr_valid", int'(channel_valid_dout), 1);
    step();
    chk("p2_stall_valid", int'(channel_valid_dout), 0);
    chk("p2_stall_zero", int'(zero_credits_dout), 1);
    chk("p2_stall_sel", int'(flit_select_dout), 2);
    step();
    chk("p2_stall2_sel", int'(flit_select_dout), 2);
    chk("p2_stall2_busy", int'(busy_engine_dout), 1);
    credit_in_din = 1'b1;        // credit at C
    step();                      // C+1: flit valid, credit held high (same-cycle flit+credit)
    chk("p2_resume_valid", int'(channel_valid_dout), 1);
    chk("p2_resume_sel", int'(flit_select_dout), 2);
    step();
    credit_in_din = 1'b0;
    chk("p2_same_cycle_count", int'(dut.credit_count_s), 1);
    chk("p2_last_valid", int'(channel_valid_dout), 1);
    step();
    chk("p2_done_busy", int'(busy_engine_dout), 0);
    chk("p2_done_zero", int'(zero_credits_dout), 1);

    // Refill and saturate credits
    credit_in_din = 1'b1;
    for (int i = 0; i < 6; i++) step();
    credit_in_din = 1'b0;
    step();
    chk("sat_count", int'(dut.credit_count_s), 4);
    chk("sat_zero", int'(zero_credits_dout), 0);

    // Reset asserted at the second flit
    done_strobe_din = 1'b1;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    step(); done_strobe_din = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_busy", int'(busy_engine_dout), 0);
    chk("mid_rst_sel", int'(flit_select_dout), 1);
    chk("mid_rst_count", int'(dut.credit_count_s), 4);
    chk("mid_rst_valid", int'(channel_valid_dout), 0);
    reset = 1'b0;
    step(); step();
    chk("post_rst_valid", int'(channel_valid_dout), 0);

    // Strobe during the last-flit cycle
    done_strobe_din = 1'b1;
    push_pkt();
    step(); done_strobe_din = 1'b0;
    step(); step();
    chk("lf_valid", int'(channel_valid_dout), 1);
    chk("lf_sel", int'(flit_select_dout), 4);
    done_strobe_din = 1'b1;
`ifdef TEST_ENGINE_NIC_TX_BACK2BACK_EN
    push_pkt();
    credit_in_din = 1'b1;
    #1 chk("lf_load", int'(load_strobe_dout), 1);
    chk("lf_busy", int'(busy_engine_dout), 0);
    step(); done_strobe_din = 1'b0;
    chk("b2b_hdr_valid", int'(channel_valid_dout), 1);
    chk("b2b_hdr_sel", int'(flit_select_dout), 1);
    step(); step(); step();
    credit_in_din = 1'b0;
    chk("b2b_end_busy", int'(busy_engine_dout), 0);
`else
    #1 chk("lf_load", int'(load_strobe_dout), 0);
    chk("lf_busy", int'(busy_engine_dout), 1);
    step(); done_strobe_din = 1'b0;
    chk("nob2b_valid", int'(channel_valid_dout), 0);
    chk("nob2b_busy", int'(busy_engine_dout), 0);
    chk("nob2b_count", int'(dut.credit_count_s), 1);
    step();
    chk("nob2b_idle_valid", int'(channel_valid_dout), 0);
`endif
    step(); step();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
